// File: rtl/ram.sv
// rtl/ram.sv - 64x8 single-port RAM with a power-up zeroing sweep.
// Define RAM_PARITY_EN to add per-word even parity and a parity_err output.
module ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ready
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
        end
    end

    // The sweep finishes on the edge that writes the last address; RUN is terminal.
    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = address;
        wdata      = din;
        case (state)
            INIT: begin
                we    = 1'b1;
                waddr = init_cnt;
                wdata = '0;
                if (&init_cnt)
                    state_next = RUN;
            end
            RUN: begin
                we = wr;
            end
            default: state_next = INIT;
        endcase
    end

    assign ready = (state == RUN);

    // Array is deliberately outside the reset domain; only the sweep clears it.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= '0;
        else if (state == INIT)
            dout <= '0;
        else if (wr)
            dout <= din;
        else
            dout <= mem[address];
    end

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            par_mem[waddr] <= ^wdata;
    end

    // Write-first reads return fresh data whose parity is correct by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else if (state == INIT || wr)
            parity_err <= 1'b0;
        else
            parity_err <= (^mem[address]) != par_mem[address];
    end
`endif

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - scoreboard testbench for ram.
module tb_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [5:0] address = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       ready;
`ifdef RAM_PARITY_EN
    logic       parity_err;
`endif

    ram #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .address(address),
        .din(din),
        .dout(dout),
        .ready(ready)
`ifdef RAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic chk = 1'b0;
    logic chk_d = 1'b0;

    always @(posedge clk) chk_d <= chk;

    // Monitor: every sampled access produces one dout, compared at the falling edge.
    always @(negedge clk) begin
        if (chk_d) begin
            exp_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: dout=%02h with no expected entry", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e.d) begin
                    fails++;
                    $display("FAIL %s: dout=%02h expected %02h", e.name, dout, e.d);
                end
`ifdef RAM_PARITY_EN
                tests++;
                if (parity_err !== e.p) begin
                    fails++;
                    $display("FAIL %s_perr: parity_err=%0b expected %0b", e.name, parity_err, e.p);
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] e, input logic p, input string name);
        exp_t x;
        x.d = e; x.p = p; x.name = name;
        exp_q.push_back(x);
        wr = 1'b0; address = a; chk = 1'b1;
        step();
        chk = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic sample, input string name);
        exp_t x;
        if (sample) begin
            x.d = d; x.p = 1'b0; x.name = name;
            exp_q.push_back(x);
        end
        wr = 1'b1; address = a; din = d; chk = sample;
        step();
        wr = 1'b0; chk = 1'b0;
    endtask

    // Release reset and count edges until ready; returns the edge count.
    task automatic sweep(input logic junk, output int edges, output logic early_bad);
        edges = 0;
        early_bad = 1'b0;
        rst = 1'b0;
        while (!ready && edges < 100) begin
            if (junk && edges < 60) begin
                wr = 1'b1; address = edges[5:0]; din = 8'h77;
            end else begin
                wr = 1'b0;
            end
            step();
            edges++;
            if (!ready && dout !== 8'h00) early_bad = 1'b1;
        end
        wr = 1'b0;
    endtask

    initial begin
        int   n;
        logic bad;

        #2;
        check("reset_ready", {7'b0, ready}, 8'h00);
        check("reset_dout", dout, 8'h00);
        repeat (2) step();

        sweep(1'b1, n, bad);
        check("init_cycles", n[7:0], 8'd64);
        check("init_dout_zero", {7'b0, bad}, 8'h00);
        check("ready_high", {7'b0, ready}, 8'h01);

        do_read(6'd0,  8'h00, 1'b0, "rd0_cleared");
        do_read(6'd31, 8'h00, 1'b0, "rd31_cleared");
        do_read(6'd63, 8'h00, 1'b0, "rd63_cleared");

        do_write(6'd5, 8'hA5, 1'b0, "");
        do_read(6'd5, 8'hA5, 1'b0, "rd5_a5");

        do_write(6'd63, 8'h3C, 1'b1, "wr63_write_first");
        do_read(6'd63, 8'h3C, 1'b0, "rd63_3c");

        do_write(6'd0,  8'h11, 1'b0, "");
        do_write(6'd63, 8'hFF, 1'b0, "");
        do_read(6'd0,  8'h11, 1'b0, "rd0_11");
        do_read(6'd63, 8'hFF, 1'b0, "rd63_ff");
        do_read(6'd1,  8'h00, 1'b0, "rd1_00");
        do_read(6'd5,  8'hA5, 1'b0, "rd5_still_a5");

`ifdef RAM_PARITY_EN
        do_write(6'd7, 8'h01, 1'b0, "");
        do_read(6'd7, 8'h01, 1'b0, "rd7_parity_ok");
        dut.par_mem[7] = ~dut.par_mem[7];
        do_read(6'd7, 8'h01, 1'b1, "rd7_parity_flip");
`endif

        // Mid-cycle asynchronous reset while dout holds a non-zero value.
        address = 6'd5;
        step();
        step();
        check("pre_rst_dout", dout, 8'hA5);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_dout", dout, 8'h00);
        check("async_rst_ready", {7'b0, ready}, 8'h00);
        step();
        sweep(1'b0, n, bad);
        check("resweep_cycles", n[7:0], 8'd64);
        do_read(6'd5, 8'h00, 1'b0, "rd5_after_rst");
        do_read(6'd63, 8'h00, 1'b0, "rd63_after_rst");

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
